ex_div_unit: RTL and testbench

Iterative 32-bit signed/unsigned divider in the execute stage, directly downstream of the ID/EX pipeline register. It consumes the EX-stage operands and DIV/DIVU decode, computes one quotient bit per cycle, and holds the pipeline through a stall request while busy. It delivers quotient (LO) and remainder (HI) with a one-cycle `done` pulse so the HI/LO write path can capture them as the instruction advances.

---
 rtl/ex_div_unit.sv | 168 ++++++++++++++++
 tb/tb_ex_div_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_div_unit.sv
// Iterative 32-bit DIV/DIVU unit for the EX stage: one restoring quotient bit per cycle.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips RUN and completes one cycle after start.
module ex_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_div,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        cancel,
    output logic        stall_req,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [4:0]  r_count;
    logic [31:0] r_prem;
    logic [31:0] r_dvd;
    logic [31:0] r_dvs;
    logic [31:0] r_dvd_raw;
    logic        r_qsign;
    logic        r_rsign;
    logic        r_dzero;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_quot;
    logic [31:0] r_rem;

    logic        w_accept;
    logic        w_div_zero_in;
    logic        w_last;
    logic [31:0] w_dvd_mag;
    logic [31:0] w_dvs_mag;
    logic [32:0] w_shift;
    logic [32:0] w_trial;
    logic [31:0] w_prem_step;
    logic [31:0] w_dvd_step;
    logic [31:0] w_quot_fix;
    logic [31:0] w_rem_fix;

    assign w_accept      = start & ~cancel;
    assign w_div_zero_in = (divisor == 32'd0);
    assign w_last        = (r_count == 5'd31);
    assign w_dvd_mag     = (signed_div & dividend[31]) ? -dividend : dividend;
    assign w_dvs_mag     = (signed_div & divisor[31])  ? -divisor  : divisor;

    // Restoring step: the quotient bits shift into the low end of the dividend register
    assign w_shift     = {r_prem, r_dvd[31]};
    assign w_trial     = w_shift - {1'b0, r_dvs};
    assign w_prem_step = w_trial[32] ? w_shift[31:0] : w_trial[31:0];
    assign w_dvd_step  = {r_dvd[30:0], ~w_trial[32]};

    assign w_quot_fix = r_dzero ? 32'hFFFF_FFFF :
                        (r_qsign ? -w_dvd_step : w_dvd_step);
    assign w_rem_fix  = r_dzero ? r_dvd_raw :
                        (r_rsign ? -w_prem_step : w_prem_step);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
`ifdef DIV_ZERO_FAST_EN
                    w_state_next = w_div_zero_in ? S_DONE : S_RUN;
`else
                    w_state_next = S_RUN;
`endif
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        if (cancel) begin
            w_state_next = S_IDLE;
        end
    end

    always_comb begin
        stall_req = 1'b0;
        case (r_state)
            S_IDLE:  stall_req = start & ~cancel;
            S_RUN:   stall_req = 1'b1;
            default: stall_req = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count   <= 5'd0;
            r_prem    <= 32'd0;
            r_dvd     <= 32'd0;
            r_dvs     <= 32'd0;
            r_dvd_raw <= 32'd0;
            r_qsign   <= 1'b0;
            r_rsign   <= 1'b0;
            r_dzero   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_quot    <= 32'd0;
            r_rem     <= 32'd0;
        end else begin
            r_busy <= (w_state_next == S_RUN);
            r_done <= (w_state_next == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_count   <= 5'd0;
                        r_prem    <= 32'd0;
                        r_dvd     <= w_dvd_mag;
                        r_dvs     <= w_dvs_mag;
                        r_dvd_raw <= dividend;
                        r_qsign   <= signed_div & (dividend[31] ^ divisor[31]);
                        r_rsign   <= signed_div & dividend[31];
                        r_dzero   <= w_div_zero_in;
`ifdef DIV_ZERO_FAST_EN
                        if (w_div_zero_in) begin
                            r_quot <= 32'hFFFF_FFFF;
                            r_rem  <= dividend;
                        end
`endif
                    end
                end
                S_RUN: begin
                    if (!cancel) begin
                        r_prem  <= w_prem_step;
                        r_dvd   <= w_dvd_step;
                        r_count <= r_count + 5'd1;
                        if (w_last) begin
                            r_quot <= w_quot_fix;
                            r_rem  <= w_rem_fix;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign quotient  = r_quot;
    assign remainder = r_rem;

endmodule

// File: tb/tb_ex_div_unit.sv
// Scoreboard bench for ex_div_unit: expected results are queued at issue and checked on done.
module tb_ex_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        signed_div = 1'b0;
    logic [31:0] dividend = 32'd0;
    logic [31:0] divisor = 32'd0;
    logic        cancel = 1'b0;
    logic        stall_req;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        string       tag;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] last_q = 32'd0;
    logic [31:0] last_r = 32'd0;

    always #5 clk = ~clk;

    ex_div_unit dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .dividend   (dividend),
        .divisor    (divisor),
        .cancel     (cancel),
        .stall_req  (stall_req),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic sg, input logic [31:0] a, input logic [31:0] b,
                                   input string tag);
        exp_t e;
        int   sa;
        int   sd;
        e.tag = tag;
        if (b == 32'd0) begin
            e.q = 32'hFFFF_FFFF;
            e.r = a;
        end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = 32'h8000_0000;
            e.r = 32'd0;
        end else if (sg) begin
            sa  = a;
            sd  = b;
            e.q = sa / sd;
            e.r = sa % sd;
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    // Scoreboard consumer
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                $display("div %s: q=0x%08h r=0x%08h (exp q=0x%08h r=0x%08h)",
                         e.tag, quotient, remainder, e.q, e.r);
                check({e.tag, "_q"}, quotient, e.q);
                check({e.tag, "_r"}, remainder, e.r);
            end
        end
    end

    // Issues one divide, measures which edge after the start edge shows done, and stall cycles.
    task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                           input string tag, input int exp_edge, input bit hold_in_done);
        exp_t e;
        int   done_edge;
        int   stall_cnt;
        e = model(sg, a, b, tag);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        start      = 1'b1;
        signed_div = sg;
        dividend   = a;
        divisor    = b;
        @(negedge clk);
        stall_cnt = stall_req ? 1 : 0;
        @(posedge clk);
        #1;
        start     = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
        done_edge = 0;
        @(negedge clk);
        while (done !== 1'b1 && done_edge < 100) begin
            if (stall_req) stall_cnt++;
            @(posedge clk);
            done_edge++;
            @(negedge clk);
        end
        check({tag, "_done_edge"}, done_edge, exp_edge);
        check({tag, "_stall_cycles"}, stall_cnt, exp_edge + 1);
        check({tag, "_stall_in_done"}, {31'd0, stall_req}, 32'd0);
        check({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
        last_q = e.q;
        last_r = e.r;
        if (hold_in_done) begin
            start = 1'b1;
            #1;
            check({tag, "_stall_start_in_done"}, {31'd0, stall_req}, 32'd0);
            @(posedge clk);
            #1;
            start = 1'b0;
        end
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        int d;
        int b;
        d = 0;
        b = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (done === 1'b1) d++;
            if (busy === 1'b1) b++;
        end
        check({tag, "_no_done"}, d, 0);
        check({tag, "_no_busy"}, b, 0);
    endtask

    localparam int LAT = 32;
`ifdef DIV_ZERO_FAST_EN
    localparam int LAT_DZ = 0;
`else
    localparam int LAT_DZ = 32;
`endif

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_stall", {31'd0, stall_req}, 32'd0);
        check("rst_quotient", quotient, 32'd0);
        check("rst_remainder", remainder, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_div(1'b0, 32'd100, 32'd7, "divu_100_7", LAT, 1'b0);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, "div_m7_2", LAT, 1'b0);
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, "div_7_m2", LAT, 1'b0);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", LAT, 1'b0);
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, "divu_max_1", LAT, 1'b0);
        run_div(1'b0, 32'h0000_1234, 32'd0, "divu_by0", LAT_DZ, 1'b0);
        run_div(1'b1, 32'hFFFF_FF00, 32'd0, "div_by0", LAT_DZ, 1'b0);
        run_div(1'b0, 32'h8000_0000, 32'h8000_0001, "divu_big", LAT, 1'b0);
        for (int i = 0; i < 6; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = (i % 3 == 0) ? $urandom_range(1, 255) : $urandom;
            if (b == 32'd0) b = 32'd3;
            run_div(i[0], a, b, $sformatf("rand%0d", i), LAT, 1'b0);
        end

        // Cancel in the middle of RUN: outputs hold the previous result, no done
        @(posedge clk);
        #1;
        start      = 1'b1;
        signed_div = 1'b0;
        dividend   = 32'd5000;
        divisor    = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        @(negedge clk);
        $display("cancel mid-run: busy=%0b q=0x%08h r=0x%08h", busy, quotient, remainder);
        check("cancel_busy", {31'd0, busy}, 32'd0);
        check("cancel_stall", {31'd0, stall_req}, 32'd0);
        check("cancel_q_hold", quotient, last_q);
        check("cancel_r_hold", remainder, last_r);
        expect_quiet("cancel", 40);
        run_div(1'b1, 32'd1000, 32'hFFFF_FFF9, "after_cancel", LAT, 1'b0);

        // Reset in the middle of RUN clears everything
        @(posedge clk);
        #1;
        start      = 1'b1;
        signed_div = 1'b0;
        dividend   = 32'd77;
        divisor    = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        $display("reset mid-run: busy=%0b q=0x%08h r=0x%08h", busy, quotient, remainder);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_quotient", quotient, 32'd0);
        check("midrst_remainder", remainder, 32'd0);
        expect_quiet("midrst", 40);

        // start held during the done cycle must not start another divide
        run_div(1'b0, 32'd99, 32'd10, "hold_start", LAT, 1'b1);
        expect_quiet("hold_start", 40);
        run_div(1'b1, 32'hFFFF_FFF0, 32'd3, "final", LAT, 1'b0);

        repeat (2) @(negedge clk);
        check("sb_drained", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
